// File: rtl/sfs_pkg.sv
// Shared state encoding and constants for serial_frame_scheduler.
package sfs_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_SEND,
      S_GAP,
      S_ERR_HOLD
   } sfs_state_e;

   localparam int FRAME_BITS      = 101;
   localparam int DEF_NREQ        = 4;
   localparam int DEF_GAP_CYC     = 4;
   localparam int DEF_TIMEOUT_CYC = 128;
   localparam int GAP_CNT_W       = 4;

endpackage

// File: rtl/sfs_rr_arbiter.sv
// Round-robin selector: combinational pick starting at r_ptr, pointer advances
// past the winner whenever the pick is taken.
module sfs_rr_arbiter
   import sfs_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_take,
   output logic [NREQ-1:0] o_gnt,
   output logic            o_any
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_win;
   logic [PW:0]   w_pos;

   always_comb begin
      o_gnt = '0;
      o_any = 1'b0;
      w_win = '0;
      w_pos = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_pos >= (PW+1)'(NREQ)) w_pos = w_pos - (PW+1)'(NREQ);
         if (!o_any && i_req[w_pos[PW-1:0]]) begin
            o_any                 = 1'b1;
            w_win                 = w_pos[PW-1:0];
            o_gnt[w_pos[PW-1:0]]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= '0;
      else if (i_take)
         r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
   end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Grants one requester at a time a 101-bit frame on the serial transmitter.
// Define SFS_TIMEOUT_EN to add the SEND watchdog (sticky err, ERR_HOLD recovery).
module serial_frame_scheduler
   import sfs_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] pol_sel,
   input  logic [NREQ-1:0] st_sel,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] done,
   output logic            tx_start,
   output logic            tx_polarity,
   output logic            tx_state,
   input  logic            tx_eoc,
   output logic            busy,
   output logic            err
);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("serial_frame_scheduler: NREQ must be 2..8");
   end
   if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_gap
      $error("serial_frame_scheduler: GAP_CYC must be 1..15");
   end
   if (TIMEOUT_CYC <= FRAME_BITS) begin : g_bad_timeout
      $error("serial_frame_scheduler: TIMEOUT_CYC must exceed the frame length");
   end

   sfs_state_e           r_state, w_next;
   logic [NREQ-1:0]      r_grant, r_done, w_arb_gnt;
   logic                 w_arb_any, w_arb_take;
   logic                 r_pol, r_st;
   logic [GAP_CNT_W-1:0] r_gap_cnt;
   logic                 w_gap_done, w_to_hit;

   sfs_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .i_req  (req),
      .i_take (w_arb_take),
      .o_gnt  (w_arb_gnt),
      .o_any  (w_arb_any)
   );

   assign w_arb_take = (r_state == S_ARB) && w_arb_any;
   // Gap ends only once the minimum spacing is met and the transmitter has released eoc.
   assign w_gap_done = (r_gap_cnt == GAP_CNT_W'(GAP_CYC - 1)) && !tx_eoc;

`ifdef SFS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC);
   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;

   assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         r_to_cnt <= (r_state == S_SEND) ? r_to_cnt + 1'b1 : '0;
         if (r_state == S_SEND && !tx_eoc && w_to_hit) r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_to_hit = 1'b0;
   assign err      = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (|req) w_next = S_ARB;
         S_ARB:      w_next = w_arb_any ? S_SEND : S_IDLE;
         S_SEND: begin
            if (tx_eoc)        w_next = S_GAP;
            else if (w_to_hit) w_next = S_ERR_HOLD;
         end
         S_GAP,
         S_ERR_HOLD: if (w_gap_done) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_done    <= '0;
         r_pol     <= 1'b0;
         r_st      <= 1'b0;
         r_gap_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= '0;
         case (r_state)
            S_ARB: if (w_arb_any) begin
               r_grant <= w_arb_gnt;
               r_pol   <= |(pol_sel & w_arb_gnt);
               r_st    <= |(st_sel & w_arb_gnt);
            end
            S_SEND: begin
               if (tx_eoc) begin
                  r_done  <= r_grant;
                  r_grant <= '0;
               end else if (w_to_hit) begin
                  r_grant <= '0;
               end
            end
            default: ;
         endcase
         if (r_state == S_GAP || r_state == S_ERR_HOLD) begin
            if (r_gap_cnt != GAP_CNT_W'(GAP_CYC - 1)) r_gap_cnt <= r_gap_cnt + 1'b1;
         end else begin
            r_gap_cnt <= '0;
         end
      end
   end

   assign grant       = r_grant;
   assign done        = r_done;
   assign tx_start    = (r_state == S_SEND);
   assign tx_polarity = r_pol;
   assign tx_state    = r_st;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Randomized self-checking bench for serial_frame_scheduler against a
// round-robin/timing model; timeout frames run when SFS_TIMEOUT_EN is defined.
module tb_serial_frame_scheduler;
   import sfs_pkg::*;

   localparam int N    = 4;
   localparam int GAP  = 4;
   localparam int TOUT = 128;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0, pol_sel = '0, st_sel = '0;
   logic [N-1:0] grant, done;
   logic         tx_start, tx_polarity, tx_state, busy, err;
   logic         tx_eoc = 1'b0;

   int checks = 0;
   int errors = 0;
   int last_owner = N - 1;
   bit exp_err = 1'b0;

   serial_frame_scheduler #(.NREQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .pol_sel     (pol_sel),
      .st_sel      (st_sel),
      .grant       (grant),
      .done        (done),
      .tx_start    (tx_start),
      .tx_polarity (tx_polarity),
      .tx_state    (tx_state),
      .tx_eoc      (tx_eoc),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester after the previous owner, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // One frame: wait for tx_start (expected latency exp_lat), check the whole
   // SEND window while scrambling selections, end it by eoc or timeout, then
   // load the next request set and hold eoc for `hold` gap cycles.
   task automatic frame(input string tag, input int exp_lat, input int rst_at, input bit no_eoc,
                        input logic [N-1:0] nreq, input logic [N-1:0] npol, input logic [N-1:0] nst,
                        input int hold, output int next_lat, output logic [N-1:0] gv);
      int   owner, lat, len, nt, glen;
      logic ep, es;
      bit   seen;
      owner = rr_pick(req, last_owner);
      ep    = pol_sel[owner];
      es    = st_sel[owner];
      lat   = 0;
      seen  = 1'b0;
      while (!seen && lat < 40) begin
         tick();
         lat++;
         seen = tx_start;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      gv = grant;
      chk({tag, "_grant"}, grant, oh(owner));
      last_owner = owner;
      len = no_eoc ? TOUT : FRAME_BITS;
      for (int k = 1; k <= len; k++) begin
         if (k > 1) tick();
         chk({tag, "_tx_start"}, tx_start, 1'b1);
         chk({tag, "_tx_polarity"}, tx_polarity, ep);
         chk({tag, "_tx_state"}, tx_state, es);
         pol_sel = N'($urandom);
         st_sel  = N'($urandom);
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            chk({tag, "_rst_tx_start"}, tx_start, 1'b0);
            chk({tag, "_rst_grant"}, grant, '0);
            chk({tag, "_rst_busy"}, busy, 1'b0);
            chk({tag, "_rst_done"}, done, '0);
            tx_eoc   = 1'b0;
            next_lat = 0;
            return;
         end
         if (k == len) begin
            chk({tag, "_err_before_end"}, err, exp_err);
            if (!no_eoc) tx_eoc = 1'b1;
         end
      end
      tick();
      if (no_eoc) exp_err = 1'b1;
      chk({tag, "_done"}, done, no_eoc ? '0 : oh(owner));
      chk({tag, "_end_tx_start"}, tx_start, 1'b0);
      chk({tag, "_end_grant"}, grant, '0);
      chk({tag, "_end_err"}, err, exp_err);
      req     = nreq;
      pol_sel = npol;
      st_sel  = nst;
      tx_eoc  = (hold > 0);
      nt      = (hold > 1) ? hold : 1;
      for (int i = 1; i <= nt; i++) begin
         tick();
         tx_eoc = (hold > i);
         if (i == 1) begin
            chk({tag, "_done_one_cycle"}, done, '0);
            chk({tag, "_gap_busy"}, busy, 1'b1);
         end
      end
      // Gap lasts GAP cycles, stretched while eoc stays high; then IDLE and ARB.
      glen     = (hold + 1 > GAP) ? hold + 1 : GAP;
      next_lat = glen + 2 - nt;
   endtask

   initial begin
      logic [N-1:0] gv;
      int           nl, hold;

      repeat (2) tick();
      chk("rst_grant", grant, '0);
      chk("rst_done", done, '0);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_polarity", tx_polarity, 1'b0);
      chk("rst_tx_state", tx_state, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      tick();
      chk("idle_no_req_busy", busy, 1'b0);

      // Request withdrawn while arbitrating: back to IDLE, no grant.
      req = 4'b0100;
      tick();
      chk("withdraw_arb_busy", busy, 1'b1);
      req = '0;
      tick();
      chk("withdraw_busy", busy, 1'b0);
      chk("withdraw_grant", grant, '0);
      tick();
      chk("withdraw_tx_start", tx_start, 1'b0);

      // Fairness with all requesters held; frame 2 holds eoc 3 cycles into the gap.
      req     = '1;
      pol_sel = N'($urandom);
      st_sel  = N'($urandom);
      nl      = 2;
      for (int f = 0; f < 8; f++) begin
         hold = (f == 2) ? 3 : int'($urandom_range(0, 6));
         frame($sformatf("fair%0d", f), nl, 0, 1'b0, (f == 7) ? {N{1'b0}} : {N{1'b1}},
               N'($urandom), N'($urandom), hold, nl, gv);
         chk($sformatf("fair%0d_order", f), gv, oh(f % N));
      end
      repeat (12) tick();
      chk("idle_after_fair", busy, 1'b0);

      // Single requester with fixed selections.
      req     = 4'b0010;
      pol_sel = 4'b0010;
      st_sel  = 4'b1101;
      frame("single", 2, 0, 1'b0, '0, '0, '0, 0, nl, gv);
      chk("single_owner", gv, 4'b0010);
      repeat (10) tick();
      chk("idle_after_single", busy, 1'b0);

      // Randomized request patterns and eoc tails.
      req     = N'($urandom_range(1, (1 << N) - 1));
      pol_sel = N'($urandom);
      st_sel  = N'($urandom);
      nl      = 2;
      for (int r = 0; r < 12; r++)
         frame($sformatf("rand%0d", r), nl, 0, 1'b0, N'($urandom_range(1, (1 << N) - 1)),
               N'($urandom), N'($urandom), int'($urandom_range(0, 6)), nl, gv);

      // Reset in the middle of a frame.
      frame("midrst", nl, 50, 1'b0, '1, '0, '0, 0, nl, gv);
      req        = '1;
      last_owner = N - 1;
      tick();
      chk("midrst_no_done", done, '0);
      chk("midrst_tx_start", tx_start, 1'b0);
      rst = 1'b0;
      frame("post_rst", 2, 0, 1'b0, 4'b0011, N'($urandom), N'($urandom), 0, nl, gv);
      chk("post_rst_owner", gv, 4'b0001);

`ifdef SFS_TIMEOUT_EN
      frame("timeout", nl, 0, 1'b1, 4'b0011, N'($urandom), N'($urandom), 0, nl, gv);
      chk("timeout_owner", gv, 4'b0010);
`endif
      frame("after", nl, 0, 1'b0, '0, '0, '0, 2, nl, gv);
      repeat (12) tick();
      chk("final_busy", busy, 1'b0);
      chk("final_err", err, exp_err);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_frame_scheduler.md
SERIAL_FRAME_SCHEDULER -- requirements
Module: serial_frame_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter GAP_CYC, default 4, minimum idle cycles with tx_start low between frames (1..15).
REQ-003 Parameter TIMEOUT_CYC, default 128, maximum cycles to wait for tx_eoc (must exceed 101).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester frame request, level, held until done.
REQ-007 pol_sel  in  NREQ  per-requester polarity selection.
REQ-008 st_sel  in  NREQ  per-requester state selection.
REQ-009 grant  out  NREQ  one-hot owner of the current frame, zero when idle.
REQ-010 done  out  NREQ  one-cycle pulse to the owner at frame end.
REQ-011 tx_start  out  1  start/enable to the serial transmitter.
REQ-012 tx_polarity  out  1  polarity selection to the transmitter.
REQ-013 tx_state  out  1  state selection to the transmitter.
REQ-014 tx_eoc  in  1  end-of-conversion from the transmitter.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err  out  1  sticky timeout flag; cleared only by rst.

Function
REQ-017 The FSM SHALL have states IDLE, ARB, SEND, GAP, ERR_HOLD.
REQ-018 IDLE: when any req bit is high, go to ARB the next cycle.
REQ-019 ARB: round-robin choice, starting at the index after the last owner (index 0 after reset); latch the winner into grant and latch its pol_sel/st_sel bits; go to SEND.
REQ-020 ARB with req all zero (request withdrawn): return to IDLE with no grant.
REQ-021 SEND: tx_start=1, tx_polarity and tx_state driven from the latched values and held constant for the whole frame.
REQ-022 Requester inputs changing during SEND SHALL NOT affect tx_polarity or tx_state.
REQ-023 SEND: on the first cycle with tx_eoc=1, drop tx_start, pulse done[owner] for one cycle, clear grant, and go to GAP.
REQ-024 GAP: stay until GAP_CYC cycles have passed AND tx_eoc=0, then go to IDLE.
REQ-025 A requester that holds req after its done SHALL NOT win again while another req bit is high.
REQ-026 Latency: req high in IDLE to tx_start high is exactly 2 cycles.
REQ-027 The arbitration pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-028 rst high SHALL force IDLE and drive these values: grant=0, done=0, tx_start=0, tx_polarity=0, tx_state=0, busy=0, err=0, round-robin pointer=0, counters=0.
REQ-029 rst asserted mid-frame SHALL drop tx_start immediately (asynchronously) and SHALL NOT generate a done pulse.

Configuration
REQ-030 Macro SFS_TIMEOUT_EN defined: a counter in SEND reaching TIMEOUT_CYC without tx_eoc SHALL drop tx_start, set err, clear grant without a done pulse, and enter ERR_HOLD.
REQ-031 ERR_HOLD SHALL run one GAP sequence and then return to IDLE, so service continues with err still high.
REQ-032 Macro SFS_TIMEOUT_EN undefined: no timeout counter, err tied to 0, ERR_HOLD unreachable, and SEND waits indefinitely.

Structure
REQ-033 Package sfs_pkg SHALL hold the state enum typedef, the frame-length constant (101 bits), and default parameter constants.
REQ-034 Sub-module sfs_rr_arbiter SHALL implement combinational round-robin selection from req and the pointer, with a registered pointer update on grant.

Verification
REQ-035 Single request: req=4'b0010, pol_sel[1]=1, st_sel[1]=0 -> grant=0010 and tx_start at +2 cycles, tx_polarity=1, tx_state=0; transmitter model eoc after 101 cycles -> done[1] pulse of 1 cycle, tx_start low.
REQ-036 Fairness: req=4'b1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Gap: transmitter model holds eoc high for 3 cycles after tx_start drops, GAP_CYC=4 -> next tx_start no sooner than 5 cycles after done.
REQ-038 Selection stability: flip pol_sel and st_sel every cycle during SEND -> tx_polarity and tx_state unchanged until done.
REQ-039 Reset mid-frame: assert rst at bit 50 -> tx_start=0 at once, no done, grant=0, next grant goes to index 0.
REQ-040 Timeout with SFS_TIMEOUT_EN: eoc never asserted -> err=1 at cycle TIMEOUT_CYC, no done, next requester served, err stays 1.
